// File: rtl/present80_pkg.sv
// rtl/present80_pkg.sv - shared constants, S-box table and FSM states for PRESENT-80 stages
package present80_pkg;

  localparam int STATE_W = 64;
  localparam int NIBBLES = 16;

  // PRESENT S-box, entry i lives at bits [4i+3:4i]: 0..F -> C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2
  localparam logic [63:0] SBOX_TABLE = 64'h21748FE3DA09B65C;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } slayer_state_e;

endpackage

// File: rtl/present80_sbox.sv
// rtl/present80_sbox.sv - single combinational 4-bit PRESENT S-box
module present80_sbox
  import present80_pkg::*;
(
  input  logic [3:0] x,
  output logic [3:0] y
);

  assign y = SBOX_TABLE[{x, 2'b00} +: 4];

endmodule

// File: rtl/present80_slayer_seq.sv
// rtl/present80_slayer_seq.sv - serialized addRoundKey + sBoxLayer stage
module present80_slayer_seq
  import present80_pkg::*;
#(
  parameter int SBOX_PER_CYCLE = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] state_in,
  input  logic [STATE_W-1:0] round_key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] state_out
);

  localparam int P  = NIBBLES / SBOX_PER_CYCLE;
  localparam int CW = (P > 1) ? $clog2(P) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(P - 1);

  slayer_state_e      state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [STATE_W-1:0] work_q;
  logic [STATE_W-1:0] work_sub;
  logic [3:0]         sb_in  [SBOX_PER_CYCLE];
  logic [3:0]         sb_out [SBOX_PER_CYCLE];
  logic               load;
  logic               step;
  logic               last;

  // Pick the nibble group addressed by cnt, lowest group first
  always_comb begin
    for (int k = 0; k < SBOX_PER_CYCLE; k++) begin
      sb_in[k] = work_q[(int'(cnt_q) * SBOX_PER_CYCLE + k) * 4 +: 4];
    end
  end

  for (genvar g = 0; g < SBOX_PER_CYCLE; g++) begin : g_sbox
    present80_sbox u_sbox (
      .x (sb_in[g]),
      .y (sb_out[g])
    );
  end

  // Write the substituted group back; all other nibbles pass through
  always_comb begin
    work_sub = work_q;
    for (int k = 0; k < SBOX_PER_CYCLE; k++) begin
      work_sub[(int'(cnt_q) * SBOX_PER_CYCLE + k) * 4 +: 4] = sb_out[k];
    end
  end

  assign last      = (cnt_q == CNT_LAST);
  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = (state_q == ST_DONE);
  assign state_out = work_q;

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        step = 1'b1;
        if (last) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, nibble counter and work register; reset wins over any handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        work_q <= state_in ^ round_key;
        cnt_q  <= '0;
      end else if (step) begin
        work_q <= work_sub;
        cnt_q  <= last ? '0 : cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_present80_slayer_seq.sv
// tb/tb_present80_slayer_seq.sv - scoreboard bench for present80_slayer_seq across parameter values
module tb_present80_slayer_seq;

  localparam int NI = 5;
  localparam int SPC_TAB [NI] = '{4, 1, 2, 8, 16};
  localparam int LAT_TAB [NI] = '{4, 16, 8, 2, 1};

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid  [NI];
  logic        in_ready  [NI];
  logic [63:0] state_in  [NI];
  logic [63:0] round_key [NI];
  logic        out_valid [NI];
  logic        out_ready [NI];
  logic [63:0] state_out [NI];

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] sb_q [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    present80_slayer_seq #(
      .SBOX_PER_CYCLE (SPC_TAB[g])
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .state_in  (state_in[g]),
      .round_key (round_key[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .state_out (state_out[g])
    );
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] sbox_ref(input logic [3:0] x);
    case (x)
      4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
      4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
      4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
      4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
    endcase
  endfunction

  function automatic logic [63:0] slayer_ref(input logic [63:0] s, input logic [63:0] k);
    logic [63:0] x;
    logic [63:0] r;
    x = s ^ k;
    for (int i = 0; i < 16; i++) r[4*i +: 4] = sbox_ref(x[4*i +: 4]);
    return r;
  endfunction

  // Entered and left at a negedge; accept happens on the next posedge
  task automatic run_txn(input int idx, input logic [63:0] s, input logic [63:0] k, input int hold);
    int n;
    logic [63:0] held;
    logic [63:0] exp;
    state_in[idx]  = s;
    round_key[idx] = k;
    in_valid[idx]  = 1'b1;
    check_eq("in_ready_idle", 64'(in_ready[idx]), 64'd1);
    sb_q.push_back(slayer_ref(s, k));
    @(negedge clk);
    in_valid[idx]  = 1'b0;
    state_in[idx]  = ~s;
    round_key[idx] = {$urandom, $urandom};
    n = 0;
    while (!out_valid[idx] && n < 200) begin
      check_eq("in_ready_busy", 64'(in_ready[idx]), 64'd0);
      @(negedge clk);
      n++;
    end
    check_eq("latency", 64'(n), 64'(LAT_TAB[idx]));
    held = state_out[idx];
    for (int h = 0; h < hold; h++) begin
      check_eq("bp_out_valid", 64'(out_valid[idx]), 64'd1);
      check_eq("bp_state_out", state_out[idx], held);
      check_eq("bp_in_ready", 64'(in_ready[idx]), 64'd0);
      @(negedge clk);
    end
    out_ready[idx] = 1'b1;
    exp = sb_q.pop_front();
    check_eq("state_out", state_out[idx], exp);
    @(negedge clk);
    out_ready[idx] = 1'b0;
    check_eq("post_hs_out_valid", 64'(out_valid[idx]), 64'd0);
    check_eq("post_hs_in_ready", 64'(in_ready[idx]), 64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b0;
      state_in[i]  = 64'hDEAD_BEEF_0BAD_F00D;
      round_key[i] = 64'h1234_5678_9ABC_DEF0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check_eq("rst_out_valid", 64'(out_valid[i]), 64'd0);
      check_eq("rst_state_out", state_out[i], 64'd0);
      check_eq("rst_in_ready", 64'(in_ready[i]), 64'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check_eq("after_rst_in_ready", 64'(in_ready[0]), 64'd1);

    // Zero vector, full S-box coverage, key XOR plus back-to-back
    run_txn(0, 64'h0, 64'h0, 0);
    check_eq("zero_vec_const", slayer_ref(64'h0, 64'h0), 64'hCCCC_CCCC_CCCC_CCCC);
    run_txn(0, 64'h0123_4567_89AB_CDEF, 64'h0, 0);
    run_txn(0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_txn(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0);

    // Backpressure
    run_txn(0, 64'hA5A5_5A5A_3C3C_C3C3, 64'h0F0F_F0F0_1234_8765, 5);

    // Reset on the second BUSY edge aborts silently
    state_in[0]  = 64'h0123_4567_89AB_CDEF;
    round_key[0] = 64'h1111_2222_3333_4444;
    in_valid[0]  = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_eq("rst_forces_in_ready", 64'(in_ready[0]), 64'd0);
    @(negedge clk);
    check_eq("abort_out_valid", 64'(out_valid[0]), 64'd0);
    check_eq("abort_state_out", state_out[0], 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("abort_in_ready", 64'(in_ready[0]), 64'd1);
    run_txn(0, 64'hFEDC_BA98_7654_3210, 64'h0011_2233_4455_6677, 0);

    // Parameter sweep
    for (int i = 1; i < NI; i++) run_txn(i, 64'h0123_4567_89AB_CDEF, 64'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/present80_slayer_seq.md
# present80_slayer_seq

Serialized addRoundKey + sBoxLayer stage of the PRESENT-80 round datapath. It accepts one 64-bit state and round key per transaction. It XORs them, then substitutes the 16 nibbles through the PRESENT S-box over several cycles using a configurable number of S-box instances. It presents the result on a valid/ready output whose data port connects directly to the permutation layer's `datain`.

## Interface
- `SBOX_PER_CYCLE`, default 4: nibbles substituted per cycle. Legal values are 1, 2, 4, 8 and 16. Derived `P = 16 / SBOX_PER_CYCLE` substitution cycles.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  upstream offers `state_in`/`round_key`.
- `in_ready`  out  1  stage can accept; high only in IDLE.
- `state_in`  in  64  cipher state; nibble i = bits [4i+3:4i].
- `round_key`  in  64  round key, i.e. key register bits [79:16].
- `out_valid`  out  1  `state_out` holds a completed result.
- `out_ready`  in  1  downstream accepts `state_out`.
- `state_out`  out  64  substituted state; feeds the pLayer input.

## Operation
- FSM states:
  - IDLE (`in_ready`=1).
  - BUSY (substituting).
  - DONE (`out_valid`=1).
- IDLE: on `in_valid && in_ready`, the work register loads `state_in ^ round_key`. Nibble counter `cnt` clears to 0. Next state is BUSY. Otherwise hold.
- BUSY, each cycle:
  - Nibbles `cnt*SBOX_PER_CYCLE` … `cnt*SBOX_PER_CYCLE+SBOX_PER_CYCLE-1` of the work register are replaced by their S-box images. Order is lowest nibble group first; other nibbles are unchanged.
  - `cnt` increments.
  - When `cnt == P-1` at the edge, the final group is written, `cnt` wraps to 0, and next state is DONE.
- DONE: `state_out` equals the work register and is held stable. On `out_valid && out_ready`, next state is IDLE. No new input is accepted in DONE.
- S-box, input 0x0…0xF → output C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
- `state_out` is driven from the work register in all states. It is meaningful only while `out_valid`=1.
- Inputs are ignored outside the IDLE accept cycle. Changes to `state_in`/`round_key` during BUSY/DONE have no effect.
- `in_valid` in BUSY/DONE is not an error; the transaction waits for the next IDLE.

## Timing
- Reset behaviour:
  - While `rst`=1 at an edge: state becomes IDLE, `cnt`=0, work register becomes 0.
  - `out_valid`=0 and `state_out`=0 after the reset edge.
  - `in_ready` is forced to 0 in any cycle where `rst`=1, and is 1 from the first cycle after reset deasserts.
- Reset has priority over every handshake. A reset during BUSY or DONE aborts the transaction silently; the result is never presented.
- Latency: with accept at edge E0, substitution happens on edges E1…EP. `out_valid` goes high after edge EP, so result latency is P edges after acceptance (4 for the default).
- Minimum transaction period is P+2 edges: accept, P substitution edges, then the output handshake edge back to IDLE.
- When `out_ready` is held low, DONE persists indefinitely with `state_out` and `out_valid` constant.
- `SBOX_PER_CYCLE`=16: BUSY lasts exactly one cycle, and `cnt` is a constant 0 of width 1.

## Structure
- Shared package `present80_pkg` holds:
  - the S-box table constant (16×4-bit);
  - the state width 64 and nibble count 16 constants;
  - the FSM state enum.
- Natural sub-module `present80_sbox` (4-bit in, 4-bit out, combinational), instantiated `SBOX_PER_CYCLE` times. The group-select mux and write-back stay in the top.
- The `cnt` width is `$clog2(P)`, with a minimum of 1.

## Test plan
- **Zero vector:** `state_in`=0, `round_key`=0, default parameter → `out_valid` rises 4 edges after accept with `state_out`=0xCCCCCCCCCCCCCCCC. `in_ready` stays 0 until the output handshake.
- **Full S-box coverage:** `state_in`=0x0123456789ABCDEF, `round_key`=0 → `state_out`=0xC56B90AD3EF84712.
- **Key XOR:** `state_in`=0, `round_key`=0xFFFFFFFFFFFFFFFF → `state_out`=0x2222222222222222. Then a second back-to-back transaction with `state_in`=0xFFFFFFFFFFFFFFFF, `round_key`=0xFFFFFFFFFFFFFFFF → 0xCCCCCCCCCCCCCCCC, accepted exactly one edge after the first output handshake.
- **Backpressure:** hold `out_ready`=0 for 5 cycles in DONE → `out_valid`=1 and `state_out` unchanged every cycle, `in_ready`=0. Raise `out_ready` → IDLE next edge.
- **Reset mid-operation:** assert `rst` on the second BUSY edge → next cycle `out_valid`=0 and `state_out`=0. The cycle after `rst` deasserts, `in_ready`=1, and a fresh transaction completes correctly.
- **Parameter sweep:** `SBOX_PER_CYCLE` ∈ {1, 2, 8, 16} with the vector 0x0123456789ABCDEF → identical 0xC56B90AD3EF84712, at latencies of 16, 8, 2 and 1 edges respectively.
